// File: rtl/grid_pkg.sv
// Shared cell states and palette for the disc-board pixel pipeline.
package grid_pkg;

  typedef enum logic [1:0] {EMPTY, P1, P2, WIN} cell_t;

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_BG     = 24'h0000FF;
  localparam logic [23:0] COL_P1     = 24'hFF0000;
  localparam logic [23:0] COL_P2     = 24'hFFFF00;
  localparam logic [23:0] COL_WIN    = 24'h00FF00;
  localparam logic [23:0] COL_CURSOR = 24'hFFFFFF;

  function automatic logic [23:0] disc_colour(input cell_t c);
    logic [23:0] v;
    unique case (c)
      EMPTY: v = COL_BLACK;
      P1:    v = COL_P1;
      P2:    v = COL_P2;
      WIN:   v = COL_WIN;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/board_store.sv
// Shadow/display boards with write handshake and per-frame commit.
// Display board is read combinationally by the pixel pipeline.
module board_store
  import grid_pkg::*;
#(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [2:0] i_wr_row,
  input  logic [2:0] i_wr_col,
  input  logic [1:0] i_wr_state,
  input  logic       i_commit,
  input  logic [2:0] i_rd_row,
  input  logic [2:0] i_rd_col,
  output logic [1:0] o_rd_state
);

  cell_t r_shadow [ROWS][COLS];
  cell_t r_disp   [ROWS][COLS];
  logic  r_dirty;
  logic  w_fire;
  logic  w_hit;
  logic  w_rd_ok;

  assign o_wr_ready = ~i_commit | ~rst_n;
  assign w_fire = i_wr_valid & o_wr_ready;
  assign w_hit = (i_wr_row < 3'(ROWS)) && (i_wr_col < 3'(COLS));
  assign w_rd_ok = (i_rd_row < 3'(ROWS)) && (i_rd_col < 3'(COLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_shadow[r][c] <= EMPTY;
          r_disp[r][c]   <= EMPTY;
        end
      end
      r_dirty <= 1'b0;
    end else if (i_commit) begin
      if (r_dirty) r_disp <= r_shadow;
      r_dirty <= 1'b0;
    end else if (w_fire && w_hit) begin
      r_shadow[i_wr_row][i_wr_col] <= cell_t'(i_wr_state);
      r_dirty <= 1'b1;
    end
  end

  assign o_rd_state = w_rd_ok ? r_disp[i_rd_row][i_rd_col] : EMPTY;

endmodule

// File: rtl/grid_renderer.sv
// Two-stage pixel colour pipeline for the disc board.
// Optional CURSOR_BLINK_EN: blink the cursor border from a frame counter.
module grid_renderer
  import grid_pkg::*;
#(
  parameter int COLS     = 7,
  parameter int ROWS     = 6,
  parameter int CELL_W   = 80,
  parameter int CELL_H   = 80,
  parameter int X_OFF    = 40,
  parameter int RADIUS   = 32,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_row,
  input  logic [2:0]  wr_col,
  input  logic [1:0]  wr_state,
  input  logic [2:0]  cursor_col,
  output logic [23:0] rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_n_out
);

  localparam int DXW = $clog2(CELL_W);
  localparam int DYW = $clog2(CELL_H);

  logic           w_commit;
  logic           w_in;
  logic [2:0]     w_row;
  logic [DYW-1:0] w_dy;
  logic [DXW-1:0] r1_dx;
  logic [2:0]     r1_col;
  logic [2:0]     r_row;
  logic [DYW-1:0] r_dy;
  logic           r1_in;
  logic           r1_hs;
  logic           r1_vs;
  logic           r1_bl;
  logic [2:0]     r_cursor;
  logic           w_blink;
  logic [1:0]     w_cell;
  logic [12:0]    w_sx;
  logic [12:0]    w_sy;
  logic [12:0]    w_dist;
  logic           w_disc;
  logic           w_edge;
  logic [23:0]    w_rgb;

  assign w_commit = (x == 10'd0) && (y == 10'(V_ACTIVE));
  assign w_in = (x >= 10'(X_OFF)) && (x < 10'(X_OFF + COLS * CELL_W))
              && (x < 10'(H_ACTIVE)) && (y < 10'(ROWS * CELL_H))
              && (y < 10'(V_ACTIVE));

  // Row decode by compare-and-subtract so a line is correct even after a jump in y.
  always_comb begin
    w_row = '0;
    w_dy  = DYW'(y);
    for (int r = 1; r < ROWS; r++) begin
      if (y >= 10'(r * CELL_H)) begin
        w_row = 3'(r);
        w_dy  = DYW'(y - 10'(r * CELL_H));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_dx  <= '0;
      r1_col <= '0;
      r_row  <= '0;
      r_dy   <= '0;
      r1_in  <= 1'b0;
      r1_hs  <= 1'b1;
      r1_vs  <= 1'b1;
      r1_bl  <= 1'b0;
    end else begin
      r1_in <= w_in;
      r1_hs <= hs_in;
      r1_vs <= vs_in;
      r1_bl <= blank_n_in;
      if (x == 10'(X_OFF)) begin
        r1_dx  <= '0;
        r1_col <= '0;
      end else if (r1_dx == DXW'(CELL_W - 1)) begin
        r1_dx  <= '0;
        r1_col <= r1_col + 3'd1;
      end else begin
        r1_dx <= r1_dx + DXW'(1);
      end
      if (x == 10'd0) begin
        r_row <= w_row;
        r_dy  <= w_dy;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cursor <= '0;
    else if (w_commit) r_cursor <= cursor_col;
  end

`ifdef CURSOR_BLINK_EN
  logic [4:0] r_frame;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_frame <= '0;
    else if (w_commit) r_frame <= r_frame + 5'd1;
  end
  assign w_blink = r_frame[4];
`else
  assign w_blink = 1'b1;
`endif

  board_store #(.COLS(COLS), .ROWS(ROWS)) u_board (
    .clk        (clk),
    .rst_n      (reset),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_row   (wr_row),
    .i_wr_col   (wr_col),
    .i_wr_state (wr_state),
    .i_commit   (w_commit),
    .i_rd_row   (r_row),
    .i_rd_col   (r1_col),
    .o_rd_state (w_cell)
  );

  assign w_sx = (r1_dx >= DXW'(CELL_W / 2))
              ? 13'(r1_dx) - 13'(CELL_W / 2)
              : 13'(CELL_W / 2) - 13'(r1_dx);
  assign w_sy = (r_dy >= DYW'(CELL_H / 2))
              ? 13'(r_dy) - 13'(CELL_H / 2)
              : 13'(CELL_H / 2) - 13'(r_dy);
  assign w_dist = 13'(w_sx * w_sx) + 13'(w_sy * w_sy);
  assign w_disc = w_dist < 13'(RADIUS * RADIUS);
  assign w_edge = (r1_col == r_cursor) && w_blink
                && ((r1_dx < DXW'(2)) || (r1_dx >= DXW'(CELL_W - 2)));

  always_comb begin
    w_rgb = COL_BG;
    if (!(r1_bl && r1_in)) w_rgb = COL_BLACK;
    else if (w_disc) w_rgb = disc_colour(cell_t'(w_cell));
    else if (w_edge) w_rgb = COL_CURSOR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb         <= '0;
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
      blank_n_out <= 1'b0;
    end else begin
      rgb         <= w_rgb;
      hs_out      <= r1_hs;
      vs_out      <= r1_vs;
      blank_n_out <= r1_bl;
    end
  end

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: partial scan lines with captured pixels.
// Default build (cursor border always on).
module tb_grid_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_n_in = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_row = '0;
  logic [2:0]  wr_col = '0;
  logic [1:0]  wr_state = '0;
  logic [2:0]  cursor_col = '0;
  logic [23:0] rgb;
  logic        hs_out;
  logic        vs_out;
  logic        blank_n_out;

  int checks = 0;
  int failures = 0;
  logic bl_kill = 1'b0;

  logic [23:0] cap_rgb [0:799];
  logic        cap_hs  [0:799];
  logic        cap_vs  [0:799];
  logic        cap_bl  [0:799];

  grid_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .blank_n_in  (blank_n_in),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_state    (wr_state),
    .cursor_col  (cursor_col),
    .rgb         (rgb),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .blank_n_out (blank_n_out)
  );

  always #20 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [23:0] got,
                     input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_xy(input int xx, input int yy);
    x = 10'(xx);
    y = 10'(yy);
    hs_in = !(xx >= 656 && xx < 752);
    vs_in = !(yy >= 490 && yy < 492);
    blank_n_in = (xx < 640) && (yy < 480) && !bl_kill;
  endtask

  // Scan x = 0..n on line yy; cap_*[k] holds the output for x = k.
  task automatic run_line(input int yy, input int n);
    for (int i = 0; i <= n; i++) begin
      set_xy(i, yy);
      @(posedge clk);
      #1;
      if (i >= 1) begin
        cap_rgb[i-1] = rgb;
        cap_hs[i-1]  = hs_out;
        cap_vs[i-1]  = vs_out;
        cap_bl[i-1]  = blank_n_out;
      end
    end
  endtask

  task automatic wr(input int row, input int col, input logic [1:0] st,
                    input string tag);
    int n = 0;
    wr_row = 3'(row);
    wr_col = 3'(col);
    wr_state = st;
    wr_valid = 1'b1;
    #1;
    while (wr_ready !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {23'd0, wr_ready}, 24'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    set_xy(700, 300);
    #5 reset = 1'b0;
    #1;
    chk("rst_rgb", rgb, 24'h000000);
    chk("rst_hs", {23'd0, hs_out}, 24'd1);
    chk("rst_vs", {23'd0, vs_out}, 24'd1);
    chk("rst_bl", {23'd0, blank_n_out}, 24'd0);
    chk("rst_rdy", {23'd0, wr_ready}, 24'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_line(0, 760);
    chk("p0_0", cap_rgb[0], 24'h000000);
    chk("p40_0", cap_rgb[40], 24'hFFFFFF);
    chk("p42_0", cap_rgb[42], 24'h0000FF);
    chk("p80_0", cap_rgb[80], 24'h0000FF);
    chk("p599_0", cap_rgb[599], 24'h0000FF);
    chk("p600_0", cap_rgb[600], 24'h000000);
    chk("hs655", {23'd0, cap_hs[655]}, 24'd1);
    chk("hs656", {23'd0, cap_hs[656]}, 24'd0);
    chk("hs751", {23'd0, cap_hs[751]}, 24'd0);
    chk("bl639", {23'd0, cap_bl[639]}, 24'd1);
    chk("bl640", {23'd0, cap_bl[640]}, 24'd0);
    run_line(40, 130);
    chk("p80_40", cap_rgb[80], 24'h000000);
    chk("p121_40", cap_rgb[121], 24'h0000FF);
    run_line(489, 4);
    chk("vs489", {23'd0, cap_vs[0]}, 24'd1);
    run_line(490, 4);
    chk("vs490", {23'd0, cap_vs[0]}, 24'd0);

    set_xy(700, 300);
    wr(5, 0, 2'd1, "wr_p1");
    run_line(440, 90);
    chk("p1_pre", cap_rgb[80], 24'h000000);
    run_line(480, 2);
    run_line(440, 90);
    chk("p1_post", cap_rgb[80], 24'hFF0000);
    bl_kill = 1'b1;
    run_line(440, 90);
    chk("blank_kill", cap_rgb[80], 24'h000000);
    bl_kill = 1'b0;

    set_xy(799, 479);
    wr_row = 3'd0;
    wr_col = 3'd1;
    wr_state = 2'd2;
    #1;
    chk("rdy_pre", {23'd0, wr_ready}, 24'd1);
    set_xy(0, 480);
    wr_valid = 1'b1;
    #1;
    chk("rdy_commit", {23'd0, wr_ready}, 24'd0);
    @(posedge clk);
    #1;
    set_xy(1, 480);
    #1;
    chk("rdy_after", {23'd0, wr_ready}, 24'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    run_line(40, 170);
    chk("held_pre", cap_rgb[160], 24'h000000);
    run_line(480, 2);
    run_line(40, 170);
    chk("held_post", cap_rgb[160], 24'hFFFF00);

    set_xy(700, 300);
    wr(6, 0, 2'd2, "wr_row6");
    wr(0, 7, 2'd2, "wr_col7");
    run_line(480, 2);
    run_line(40, 570);
    chk("oor_c6", cap_rgb[560], 24'h000000);
    chk("oor_c0", cap_rgb[80], 24'h000000);
    chk("oor_c1", cap_rgb[160], 24'hFFFF00);
    run_line(440, 90);
    chk("oor_r5", cap_rgb[80], 24'hFF0000);

    cursor_col = 3'd3;
    run_line(40, 365);
    chk("cur_old", cap_rgb[40], 24'hFFFFFF);
    run_line(480, 2);
    run_line(40, 365);
    chk("cur_c0", cap_rgb[40], 24'h0000FF);
    chk("cur_280", cap_rgb[280], 24'hFFFFFF);
    chk("cur_281", cap_rgb[281], 24'hFFFFFF);
    chk("cur_282", cap_rgb[282], 24'h0000FF);
    chk("cur_disc", cap_rgb[320], 24'h000000);
    chk("cur_359", cap_rgb[359], 24'hFFFFFF);
    chk("cur_360", cap_rgb[360], 24'h0000FF);

    run_line(200, 123);
    chk("pre_rst", rgb, 24'h0000FF);
    reset = 1'b0;
    #1;
    chk("mid_rgb", rgb, 24'h000000);
    chk("mid_bl", {23'd0, blank_n_out}, 24'd0);
    chk("mid_hs", {23'd0, hs_out}, 24'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_line(201, 300);
    chk("rs_c0", cap_rgb[40], 24'hFFFFFF);
    chk("rs_disc", cap_rgb[80], 24'h000000);
    chk("rs_281", cap_rgb[281], 24'h0000FF);
    run_line(40, 170);
    chk("rs_p2", cap_rgb[160], 24'h000000);
    run_line(440, 90);
    chk("rs_p1", cap_rgb[80], 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
